// File: rtl/assoc_cache_if.sv
// Lookup/write port and flush write-back channel of assoc_cache.
// Flush channel holds each line until flush_ack; lookup/write have no backpressure.
interface assoc_cache_if #(
    parameter int ADDR_W = 14,
    parameter int LINE_W = 64,
    parameter int SETS   = 8
);
    localparam int TAG_W = ADDR_W - $clog2(SETS);

    logic [ADDR_W-1:0] addr;
    logic              re;
    logic              we;
    logic [LINE_W-1:0] wr_data;
    logic              wdirty;
    logic              hit;
    logic              dirty;
    logic [LINE_W-1:0] rd_data;
    logic [TAG_W-1:0]  tag_out;
    logic              flush_req;
    logic              flush_busy;
    logic              flush_valid;
    logic [ADDR_W-1:0] flush_addr;
    logic [LINE_W-1:0] flush_data;
    logic              flush_ack;
    logic              flush_done;

    modport master (
        output addr, re, we, wr_data, wdirty, flush_req, flush_ack,
        input  hit, dirty, rd_data, tag_out, flush_busy, flush_valid,
               flush_addr, flush_data, flush_done
    );

    modport slave (
        input  addr, re, we, wr_data, wdirty, flush_req, flush_ack,
        output hit, dirty, rd_data, tag_out, flush_busy, flush_valid,
               flush_addr, flush_data, flush_done
    );
endinterface

// File: rtl/assoc_cache.sv
// N-way set-associative line store, true-LRU, 1-cycle registered lookup, dirty-line flush walker.
// Flush presentations stall on flush_ack; re/we/flush_req are dropped while flush_busy.
module assoc_cache #(
    parameter int ADDR_W = 14,
    parameter int LINE_W = 64,
    parameter int SETS   = 8,
    parameter int WAYS   = 2
) (
    input logic          clk,
    input logic          rst_n,
    assoc_cache_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, PRESENT, DONE} state_t;

    state_t state_q, state_d;

    logic              vld_q  [SETS][WAYS];
    logic              drt_q  [SETS][WAYS];
    logic [WAY_W-1:0]  age_q  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q  [SETS][WAYS];
    logic [LINE_W-1:0] data_q [SETS][WAYS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tg;
    logic             hit_any, inv_any;
    logic [WAY_W-1:0] hit_way, inv_way, old_way, victim, sel;
    logic             rd_en, wr_en, lru_upd;

    logic [IDX_W-1:0] ps;
    logic [WAY_W-1:0] pw;
    logic             last, cur_dirty, ptr_clr, ptr_adv, clr_dirty, done_set;

    logic              hit_r, dirty_r, done_r;
    logic [LINE_W-1:0] rd_data_r;
    logic [TAG_W-1:0]  tag_out_r;

    assign idx = bus.addr[IDX_W-1:0];
    assign tg  = bus.addr[ADDR_W-1:IDX_W];

    // Descending scan so the lowest-index matching/invalid way wins.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        old_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (vld_q[idx][w] && tag_q[idx][w] == tg) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!vld_q[idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
            if (age_q[idx][w] == WAY_W'(WAYS - 1)) old_way = WAY_W'(w);
        end
        victim = inv_any ? inv_way : old_way;
        sel    = hit_any ? hit_way : victim;
    end

    assign rd_en   = bus.re && (state_q == IDLE);
    assign wr_en   = bus.we && (state_q == IDLE);
    assign lru_upd = (rd_en && hit_any) || wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_r     <= 1'b0;
            dirty_r   <= 1'b0;
            rd_data_r <= '0;
            tag_out_r <= '0;
        end else if (rd_en) begin
            hit_r     <= hit_any;
            dirty_r   <= vld_q[idx][sel] && drt_q[idx][sel];
            rd_data_r <= data_q[idx][sel];
            tag_out_r <= tag_q[idx][sel];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    vld_q[s][w] <= 1'b0;
                    drt_q[s][w] <= 1'b0;
                    age_q[s][w] <= WAY_W'(w);
                end
            end
        end else begin
            if (wr_en) begin
                vld_q[idx][sel] <= 1'b1;
                drt_q[idx][sel] <= bus.wdirty;
            end
            if (clr_dirty) drt_q[ps][pw] <= 1'b0;
            if (lru_upd) begin
                for (int v = 0; v < WAYS; v++) begin
                    if (age_q[idx][v] < age_q[idx][sel]) age_q[idx][v] <= age_q[idx][v] + 1'b1;
                end
                age_q[idx][sel] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[idx][sel]  <= tg;
            data_q[idx][sel] <= bus.wr_data;
        end
    end

    assign last      = (ps == IDX_W'(SETS - 1)) && (pw == WAY_W'(WAYS - 1));
    assign cur_dirty = vld_q[ps][pw] && drt_q[ps][pw];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ps      <= '0;
            pw      <= '0;
            done_r  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_r  <= done_set;
            if (ptr_clr) begin
                ps <= '0;
                pw <= '0;
            end else if (ptr_adv) begin
                if (pw == WAY_W'(WAYS - 1)) begin
                    pw <= '0;
                    ps <= ps + 1'b1;
                end else begin
                    pw <= pw + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_clr   = 1'b0;
        ptr_adv   = 1'b0;
        clr_dirty = 1'b0;
        done_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flush_req) begin
                    state_d = SCAN;
                    ptr_clr = 1'b1;
                end
            end
            SCAN: begin
                if (cur_dirty) begin
                    state_d = PRESENT;
                end else begin
                    ptr_adv = 1'b1;
                    if (last) state_d = DONE;
                end
            end
            PRESENT: begin
                if (bus.flush_ack) begin
                    clr_dirty = 1'b1;
                    ptr_adv   = 1'b1;
                    state_d   = last ? DONE : SCAN;
                end
            end
            DONE: begin
                done_set = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.hit         = hit_r;
    assign bus.dirty       = dirty_r;
    assign bus.rd_data     = rd_data_r;
    assign bus.tag_out     = tag_out_r;
    assign bus.flush_busy  = (state_q != IDLE);
    assign bus.flush_valid = (state_q == PRESENT);
    assign bus.flush_addr  = (state_q == PRESENT) ? {tag_q[ps][pw], ps} : '0;
    assign bus.flush_data  = (state_q == PRESENT) ? data_q[ps][pw] : '0;
    assign bus.flush_done  = done_r;
endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache with a recency-list model checked every cycle.
module tb_assoc_cache;
    localparam int ADDR_W = 14;
    localparam int LINE_W = 64;
    localparam int SETS   = 8;
    localparam int WAYS   = 2;
    localparam int IDX_W  = 3;
    localparam int TAG_W  = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    assoc_cache_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .SETS(SETS)) bus ();
    assoc_cache #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .SETS(SETS), .WAYS(WAYS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Model: contents per way plus a most-recent-first way list per set.
    bit                m_valid [SETS][WAYS];
    bit                m_dirty [SETS][WAYS];
    logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
    logic [LINE_W-1:0] m_data  [SETS][WAYS];
    int                mru     [SETS][WAYS];
    bit                m_busy = 1'b0;
    bit                cmp_on = 1'b0;
    bit                e_hit = 1'b0, e_dirty = 1'b0, e_known = 1'b1;
    logic [LINE_W-1:0] e_data = '0;
    logic [TAG_W-1:0]  e_tag = '0;
    int                ms, mhw, msel;
    logic [TAG_W-1:0]  mt;
    logic [ADDR_W-1:0] pres_log[$];

    function automatic int m_victim(input int s);
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
        return mru[s][WAYS-1];
    endfunction

    task automatic m_touch(input int s, input int w);
        int p = 0;
        for (int k = 0; k < WAYS; k++) if (mru[s][k] == w) p = k;
        for (int k = p; k > 0; k--) mru[s][k] = mru[s][k-1];
        mru[s][0] = w;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    m_valid[s][w] = 1'b0;
                    m_dirty[s][w] = 1'b0;
                    mru[s][w]     = w;
                end
            end
            e_hit = 1'b0; e_dirty = 1'b0; e_data = '0; e_tag = '0; e_known = 1'b1;
        end else if (!m_busy) begin
            ms  = int'(bus.addr[IDX_W-1:0]);
            mt  = bus.addr[ADDR_W-1:IDX_W];
            mhw = -1;
            for (int w = 0; w < WAYS; w++)
                if (mhw < 0 && m_valid[ms][w] && m_tag[ms][w] == mt) mhw = w;
            msel = (mhw >= 0) ? mhw : m_victim(ms);
            if (bus.re) begin
                e_hit   = (mhw >= 0);
                e_dirty = m_valid[ms][msel] && m_dirty[ms][msel];
                e_data  = m_data[ms][msel];
                e_tag   = m_tag[ms][msel];
                e_known = e_hit || m_valid[ms][msel];
            end
            if ((bus.re && mhw >= 0) || bus.we) m_touch(ms, msel);
            if (bus.we) begin
                m_valid[ms][msel] = 1'b1;
                m_dirty[ms][msel] = bus.wdirty;
                m_tag[ms][msel]   = mt;
                m_data[ms][msel]  = bus.wr_data;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("hit", 64'(bus.hit), 64'(e_hit));
            chk("dirty", 64'(bus.dirty), 64'(e_dirty));
            if (e_known) begin
                chk("rd_data", bus.rd_data, e_data);
                chk("tag_out", 64'(bus.tag_out), 64'(e_tag));
            end
            if (!m_busy) chk("flush_valid_idle", 64'(bus.flush_valid), 64'd0);
        end
    end

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d, input bit dt);
        @(negedge clk);
        bus.addr = a; bus.wr_data = d; bus.wdirty = dt; bus.we = 1'b1;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        @(negedge clk);
        bus.addr = a; bus.re = 1'b1;
        @(negedge clk);
        bus.re = 1'b0;
    endtask

    // n counts posedges since the edge that sampled flush_req.
    task automatic do_flush(input int ack_delay, input bit inject, output int done_n, output int npres);
        logic [ADDR_W-1:0] exp_a[$];
        logic [LINE_W-1:0] exp_d[$];
        int exp_s[$], exp_w[$];
        int pres_n = -1;
        pres_log.delete();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                if (m_valid[s][w] && m_dirty[s][w]) begin
                    exp_a.push_back({m_tag[s][w], IDX_W'(s)});
                    exp_d.push_back(m_data[s][w]);
                    exp_s.push_back(s);
                    exp_w.push_back(w);
                end
            end
        end
        done_n = -1;
        npres  = 0;
        @(negedge clk) bus.flush_req = 1'b1;
        @(negedge clk) bus.flush_req = 1'b0;
        m_busy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (bus.flush_done) begin
                done_n = n;
                break;
            end
            bus.flush_ack = 1'b0;
            if (bus.flush_valid) begin
                if (pres_n < 0) begin
                    pres_n = n;
                    npres++;
                    pres_log.push_back(bus.flush_addr);
                    chk("presentation_count", 64'(npres <= exp_a.size()), 64'd1);
                end
                if (npres > 0 && npres <= exp_a.size()) begin
                    chk("flush_addr", 64'(bus.flush_addr), 64'(exp_a[npres-1]));
                    chk("flush_data", bus.flush_data, exp_d[npres-1]);
                    if (n == pres_n + ack_delay - 1) begin
                        bus.flush_ack = 1'b1;
                        m_dirty[exp_s[npres-1]][exp_w[npres-1]] = 1'b0;
                    end
                end
            end else begin
                pres_n = -1;
            end
            if (inject && n == 2) begin
                bus.addr = 14'h033; bus.wr_data = 64'h3333_0000_3333_0000;
                bus.wdirty = 1'b1; bus.we = 1'b1; bus.re = 1'b1;
            end else if (inject && n == 3) begin
                bus.we = 1'b0; bus.re = 1'b0;
            end
            @(negedge clk);
        end
        bus.flush_ack = 1'b0;
        m_busy = 1'b0;
        chk("flush_done_seen", 64'(done_n >= 0), 64'd1);
        @(negedge clk);
        chk("flush_done_single", 64'(bus.flush_done), 64'd0);
        chk("flush_busy_after", 64'(bus.flush_busy), 64'd0);
    endtask

    int dn, np;
    bit found;

    initial begin
        bus.addr = '0; bus.re = 1'b0; bus.we = 1'b0; bus.wr_data = '0; bus.wdirty = 1'b0;
        bus.flush_req = 1'b0; bus.flush_ack = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cmp_on = 1'b1;

        chk("rst_hit", 64'(bus.hit), 64'd0);
        chk("rst_dirty", 64'(bus.dirty), 64'd0);
        chk("rst_rd_data", bus.rd_data, 64'd0);
        chk("rst_tag_out", 64'(bus.tag_out), 64'd0);
        chk("rst_flush_valid", 64'(bus.flush_valid), 64'd0);
        chk("rst_flush_busy", 64'(bus.flush_busy), 64'd0);
        chk("rst_flush_done", 64'(bus.flush_done), 64'd0);
        chk("rst_flush_addr", 64'(bus.flush_addr), 64'd0);
        chk("rst_flush_data", bus.flush_data, 64'd0);

        rd(14'h005);
        chk("empty_hit", 64'(bus.hit), 64'd0);
        chk("empty_dirty", 64'(bus.dirty), 64'd0);

        wr(14'h015, 64'h1111_2222_3333_4444, 1'b0);
        rd(14'h015);
        chk("wr_rd_hit", 64'(bus.hit), 64'd1);
        chk("wr_rd_data", bus.rd_data, 64'h1111_2222_3333_4444);
        chk("wr_rd_tag", 64'(bus.tag_out), 64'h002);
        chk("wr_rd_dirty", 64'(bus.dirty), 64'd0);

        wr(14'h01D, 64'hAAAA_0000_0000_0003, 1'b0);
        rd(14'h015);
        wr(14'h025, 64'hBBBB_0000_0000_0004, 1'b1);
        rd(14'h01D);
        chk("evicted_hit", 64'(bus.hit), 64'd0);
        chk("evicted_victim_tag", 64'(bus.tag_out), 64'h002);
        chk("evicted_victim_dirty", 64'(bus.dirty), 64'd0);
        rd(14'h025);
        chk("new_hit", 64'(bus.hit), 64'd1);
        chk("new_dirty", 64'(bus.dirty), 64'd1);
        wr(14'h025, 64'hBBBB_0000_0000_0004, 1'b0);

        wr(14'h081, 64'h0081_0081_0081_0081, 1'b1);
        wr(14'h006, 64'h0006_0006_0006_0006, 1'b0);
        wr(14'h106, 64'h0106_0106_0106_0106, 1'b1);
        do_flush(3, 1'b1, dn, np);
        chk("flush_presentations", 64'(np), 64'd2);
        chk("flush_cycles", 64'(dn), 64'(SETS * WAYS + 1 + 2 * 3));
        if (pres_log.size() == 2) begin
            chk("flush_first_addr", 64'(pres_log[0]), 64'h081);
            chk("flush_second_addr", 64'(pres_log[1]), 64'h106);
        end
        rd(14'h081);
        chk("flushed_a_hit", 64'(bus.hit), 64'd1);
        chk("flushed_a_dirty", 64'(bus.dirty), 64'd0);
        rd(14'h106);
        chk("flushed_b_hit", 64'(bus.hit), 64'd1);
        chk("flushed_b_dirty", 64'(bus.dirty), 64'd0);
        rd(14'h033);
        chk("busy_write_ignored", 64'(bus.hit), 64'd0);

        wr(14'h081, 64'hDEAD_BEEF_0000_0081, 1'b1);
        rd(14'h081);
        chk("pre_reset_hit", 64'(bus.hit), 64'd1);
        @(negedge clk) bus.flush_req = 1'b1;
        @(negedge clk) bus.flush_req = 1'b0;
        m_busy = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.flush_valid) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("mid_flush_presenting", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_flush_valid", 64'(bus.flush_valid), 64'd0);
        chk("async_flush_busy", 64'(bus.flush_busy), 64'd0);
        chk("async_hit", 64'(bus.hit), 64'd0);
        m_busy = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        do_flush(3, 1'b0, dn, np);
        chk("clean_flush_presentations", 64'(np), 64'd0);
        chk("clean_flush_cycles", 64'(dn), 64'(SETS * WAYS + 1));
        rd(14'h081);
        chk("post_reset_miss", 64'(bus.hit), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
